// File: rtl/decoder_stream.sv
// decoder_stream: registered, flow-controlled binary decoder.
//   A code and a mode are accepted over a valid/ready handshake. The decoded
//   word is held in a 2-entry output buffer.
//   Modes: 00 one-hot, 01 thermometer, 10 inverted one-hot, 11 reserved.
//   A code at or above OUTPUT_WIDTH, or the reserved mode, gives a zero word
//   with err set. Such a transfer also bumps a saturating counter.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   in_code, in_mode    encoded input and decode mode
//   in_valid, in_rdy    input handshake (in_rdy depends on registered state only)
//   out_word, out_err   head entry of the output buffer
//   out_valid, out_rdy  output handshake
//   err_cnt             saturating count of accepted erroneous transfers
//   err_cnt_clr         synchronous clear of err_cnt (wins over an increment)
module decoder_stream #(
  parameter int INPUT_WIDTH   = 5,
  parameter int OUTPUT_WIDTH  = 2**INPUT_WIDTH,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [INPUT_WIDTH-1:0]   in_code,
  input  logic [1:0]               in_mode,
  input  logic                     in_valid,
  output logic                     in_rdy,
  output logic [OUTPUT_WIDTH-1:0]  out_word,
  output logic                     out_err,
  output logic                     out_valid,
  input  logic                     out_rdy,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  input  logic                     err_cnt_clr
);

  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  logic [1:0]              count;
  logic [OUTPUT_WIDTH-1:0] head_word, tail_word;
  logic                    head_err, tail_err;
  logic [OUTPUT_WIDTH-1:0] dec_word;
  logic                    dec_err;
  logic [31:0]             code_ext;
  logic                    push, pop;

  assign code_ext = 32'(in_code);

  always_comb begin
    dec_word = '0;
    dec_err  = 1'b0;
    if (in_mode == 2'b11 || code_ext >= 32'(OUTPUT_WIDTH)) begin
      dec_err = 1'b1;
    end else begin
      for (int i = 0; i < OUTPUT_WIDTH; i++) begin
        case (in_mode)
          2'b00:   dec_word[i] = (32'(i) == code_ext);
          2'b01:   dec_word[i] = (32'(i) <= code_ext);
          default: dec_word[i] = (32'(i) != code_ext);
        endcase
      end
    end
  end

  assign in_rdy    = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_word  = head_word;
  assign out_err   = head_err;
  assign push      = in_valid & in_rdy;
  assign pop       = out_valid & out_rdy;

  // The head register always drives the output. The tail is only used at
  // count=2. When a push and a pop happen together at count=1, the new entry
  // goes straight into the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= 2'd0;
      head_word <= '0;
      head_err  <= 1'b0;
      tail_word <= '0;
      tail_err  <= 1'b0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_word <= dec_word;
            head_err  <= dec_err;
            count     <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_word <= dec_word;
            head_err  <= dec_err;
          end else if (push) begin
            tail_word <= dec_word;
            tail_err  <= dec_err;
            count     <= 2'd2;
          end else if (pop) begin
            count     <= 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_word <= tail_word;
            head_err  <= tail_err;
            count     <= 2'd1;
          end
        end
        default: count <= 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (push && dec_err && err_cnt != ERR_MAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: doc/decoder_stream.md
Name: decoder_stream

Overview:
- Registered, flow-controlled successor to the combinational binary decoder.
- Accepts a binary code plus per-transfer mode over a valid/ready handshake; emits the decoded word through a 2-entry output buffer.
- Output modes: one-hot, thermometer, inverted one-hot.
- Flags codes outside OUTPUT_WIDTH and keeps a saturating error count.
- Used in front of per-port/per-queue select logic where the decoded word must be registered and back-pressured.

Parameters:
- INPUT_WIDTH, 5: width of encoded input.
- OUTPUT_WIDTH, 2**INPUT_WIDTH: decoded word width; may be less than 2**INPUT_WIDTH (codes >= OUTPUT_WIDTH are out of range).
- ERR_CNT_WIDTH, 16: width of the saturating out-of-range counter.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- in_code  input  INPUT_WIDTH  binary code.
- in_mode  input  2  00 one-hot, 01 thermometer, 10 inverted one-hot, 11 reserved.
- in_valid  input  1  in_code/in_mode valid.
- in_rdy  output  1  block can accept a transfer this cycle.
- out_word  output  OUTPUT_WIDTH  decoded word (head entry).
- out_err  output  1  head entry was out of range or used reserved mode.
- out_valid  output  1  head entry valid.
- out_rdy  input  1  downstream accepts head entry.
- err_cnt  output  ERR_CNT_WIDTH  saturating count of accepted erroneous transfers.
- err_cnt_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Clocking/reset: one clock domain; reset is asynchronous and active-high; all state on posedge clk.
- Reset values: buffer count=0, out_valid=0, in_rdy=1, out_word=0, out_err=0, err_cnt=0. Assertion mid-operation drops all buffered entries immediately; nothing is emitted after release until new input is accepted.
- Transfers: input accepted when in_valid & in_rdy; output consumed when out_valid & out_rdy.
- Buffer: 2-entry FIFO holding {word, err}.
  - in_rdy = (count < 2), decoded from registered state only; no combinational path from out_rdy or in_valid to in_rdy.
  - out_valid = (count != 0).
  - out_word/out_err driven from the head entry, stable while out_valid & !out_rdy.
- Latency: input accepted in cycle N appears at the output in cycle N+1 when the buffer was empty, or when count was 1 and the head was popped in cycle N.
- Throughput: with out_rdy held high, 1 transfer/cycle sustained.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together at count=1: count stays 1, new entry becomes head next cycle.
  - push at count=2: cannot occur (in_rdy=0).
  - pop at count=0: ignored.
- Decode, for in range (in_code < OUTPUT_WIDTH), with k = in_code:
  - mode 00: only bit k set.
  - mode 01: bits 0..k set, all others 0. k=0 gives 1; k=OUTPUT_WIDTH-1 gives all ones.
  - mode 10: all bits set except bit k.
- Errors:
  - Out of range (in_code >= OUTPUT_WIDTH, possible only when OUTPUT_WIDTH < 2**INPUT_WIDTH): word = 0 in every mode, err = 1.
  - mode 11: word = 0, err = 1, regardless of code.
- err_cnt:
  - Increments by 1 on each accepted transfer with err=1.
  - Saturates at all ones.
  - err_cnt_clr forces 0 next cycle; if clear and an error increment occur in the same cycle, result is 0 (clear wins).
  - Counted at acceptance, not at output.

Test Plan:
1. INPUT_WIDTH=5, reset released, out_rdy=1; push code 3 mode 00 -> next cycle out_valid=1, out_word=32'h0000_0008, out_err=0; in_rdy stays 1.
2. Stream codes 0..31, mode 01, out_rdy=1 -> one output per cycle, 1-cycle latency, word for code 4 = 32'h0000_001F, code 31 = 32'hFFFF_FFFF.
3. out_rdy=0, push codes 1,2 (mode 10) -> in_rdy=0 after second push, out_word=32'hFFFF_FFFD held; raise out_rdy -> FFFF_FFFD then FFFF_FFFB, in_rdy=1 after first pop.
4. OUTPUT_WIDTH=20: push code 25 mode 00, then code 2 mode 11 -> both outputs word=0, out_err=1; err_cnt=2.
5. ERR_CNT_WIDTH=2: 5 error transfers -> err_cnt saturates at 3; err_cnt_clr concurrent with a 6th error -> err_cnt=0.
6. Buffer at count=2, assert reset mid-cycle -> out_valid=0, in_rdy=1, err_cnt=0 asynchronously; no stale word after release.
